// File: rtl/wb16_bus_master.sv
// wb16_bus_master
// Classic-cycle Wishbone initiator for a 16-bit data bus. Each accepted
// command becomes exactly one single-beat Wishbone cycle. The cycle ends with
// either the slave's ack (carrying read data) or a timeout error, and the
// result is offered on a valid/ready response channel. The next command is
// accepted only after the response has been consumed.
module wb16_bus_master #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,

    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_err,

    // Wishbone initiator port
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  wbm_we_o,
    output logic [SEL_WIDTH-1:0]  wbm_sel_o,
    output logic                  wbm_stb_o,
    input  logic                  wbm_ack_i,
    output logic                  wbm_cyc_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The timeout fires on the edge where the counter already holds
    // TIMEOUT_CYCLES-1, so strobe stays high for exactly TIMEOUT_CYCLES
    // cycles. The comparison is done at 32 bits so a large parameter cannot
    // alias onto a small count; because the counter saturates at 16 bits,
    // values above 65536 simply never expire.
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t                  state_reg;
    logic [15:0]             timeout_cnt_reg;
    logic                    cmd_ready_reg;
    logic                    rsp_valid_reg;
    logic [DATA_WIDTH-1:0]   rsp_dat_reg;
    logic                    rsp_err_reg;
    logic [ADDR_WIDTH-1:0]   adr_reg;
    logic [DATA_WIDTH-1:0]   dat_reg;
    logic                    we_reg;
    logic [SEL_WIDTH-1:0]    sel_reg;
    logic                    cyc_reg;
    logic                    stb_reg;
    logic                    timeout_hit;

    // Timeout condition for the current BUS cycle (ack takes priority in the FSM).
    always_comb begin
        timeout_hit = 1'b0;
        if (TO_EN && ({16'd0, timeout_cnt_reg} == TO_LAST)) begin
            timeout_hit = 1'b1;
        end
    end

    // Main controller: state, Wishbone drive, counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            timeout_cnt_reg <= '0;
            cmd_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_dat_reg     <= '0;
            rsp_err_reg     <= 1'b0;
            adr_reg         <= '0;
            dat_reg         <= '0;
            we_reg          <= 1'b0;
            sel_reg         <= '0;
            cyc_reg         <= 1'b0;
            stb_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // cmd_ready_reg is always 1 here, so cmd_valid alone
                    // means a handshake on this edge.
                    if (cmd_valid) begin
                        adr_reg         <= cmd_adr;
                        dat_reg         <= cmd_dat;
                        we_reg          <= cmd_we;
                        sel_reg         <= cmd_sel;
                        cyc_reg         <= 1'b1;
                        stb_reg         <= 1'b1;
                        cmd_ready_reg   <= 1'b0;
                        timeout_cnt_reg <= '0;
                        state_reg       <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (wbm_ack_i) begin
                        // Normal completion; also wins over a coincident timeout.
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        sel_reg       <= '0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_dat_reg   <= we_reg ? '0 : wbm_dat_i;
                        state_reg     <= ST_RESP;
                    end else if (timeout_hit) begin
                        // Abort: release the bus and report an error with no data.
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        sel_reg       <= '0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_dat_reg   <= '0;
                        state_reg     <= ST_RESP;
                    end else if (timeout_cnt_reg != CNT_MAX) begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
                end

                ST_RESP: begin
                    // Hold the response until consumed; bus acks are ignored.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    cyc_reg       <= 1'b0;
                    stb_reg       <= 1'b0;
                    we_reg        <= 1'b0;
                    sel_reg       <= '0;
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_dat   = rsp_dat_reg;
    assign rsp_err   = rsp_err_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_sel_o = sel_reg;
    assign wbm_stb_o = stb_reg;
    assign wbm_cyc_o = cyc_reg;

endmodule
